// File: rtl/curve25519_pkg.sv
// Shared curve25519 field constants and the multiplier-arbiter state encoding.
package curve25519_pkg;

    localparam int N = 255;
    localparam logic [N-1:0] P = {{(N-5){1'b1}}, 5'b01101};

    typedef logic [N-1:0] fe_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin grant: searches req from last+1 with wrap, one-hot result.
// Zero latency; the pointer register lives in the parent.
module rr_arb
    import curve25519_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id
);

    int               pos;
    logic             found;
    logic [ID_W-1:0]  idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        pos    = 0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = int'(last) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = ID_W'(pos);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/mult_modp_arb.sv
// Round-robin share of one mult_modp: accept, 1-cycle restart, run until rdy or timeout.
// Accept at T, RUN from T+2, response the cycle after rdy; result held while resp_ready=0.
module mult_modp_arb #(
    parameter int NREQ    = 4,
    parameter int N       = 255,
    parameter int TIMEOUT = 512,
    parameter int ID_W    = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_x,
    input  logic [NREQ*N-1:0]   req_y,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [ID_W-1:0]     resp_id,
    output logic [N-1:0]        resp_prod,
    output logic                resp_err,
    output logic                mul_en,
    output logic                mul_rst_n,
    output logic [N-1:0]        mul_x,
    output logic [N-1:0]        mul_y,
    input  logic [N-1:0]        mul_prod,
    input  logic                mul_rdy
);
    import curve25519_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [N-1:0]    x_q, x_d, y_q, y_d;
    logic [N-1:0]    prod_q, prod_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic [N-1:0]    sel_x, sel_y;
    logic            mul_rst_n_c;

    rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_rr_arb (
        .req    (req_valid),
        .last   (rr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_x = req_x[i*N +: N];
                sel_y = req_y[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        x_d         = x_q;
        y_d         = y_q;
        prod_d      = prod_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        req_ready   = '0;
        resp_valid  = 1'b0;
        mul_en      = 1'b0;
        mul_rst_n_c = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready = rst_n ? gnt : '0;
                if (|req_ready) begin
                    x_d     = sel_x;
                    y_d     = sel_y;
                    id_d    = gnt_id;
                    rr_d    = gnt_id;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mul_rst_n_c = 1'b0;
                cnt_d       = '0;
                state_d     = RUN;
            end
            RUN: begin
                mul_en = 1'b1;
                if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
                // cnt_q==0 marks the first RUN cycle, where a stale rdy may still show
                if (cnt_q != '0 && mul_rdy) begin
                    prod_d  = mul_prod;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= ID_W'(NREQ - 1);
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mul_rst_n = rst_n & mul_rst_n_c;
    assign mul_x     = x_q;
    assign mul_y     = y_q;
    assign resp_id   = id_q;
    assign resp_prod = prod_q;
    assign resp_err  = err_q;

endmodule

// File: doc/mult_modp_arb.md
Name: mult_modp_arb

Overview:
Shares one mult_modp instance among NREQ requesters (point-add, ladder step and inversion sequencers) with round-robin arbitration. Per job, the block:
- captures the operands,
- restarts the multiplier with a one-cycle mul_rst_n pulse,
- runs it with mul_en until mul_rdy,
- returns the product tagged with the requester id.
A timeout guards against a hung multiplier.

Parameters:
NREQ, 4, number of requesters (2..8)
N, 255, operand/product width
TIMEOUT, 512, max RUN cycles before abort
ID_W, $clog2(NREQ), requester id width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request; held until accepted
req_ready  out  NREQ  one-hot grant; handshake on valid&ready
req_x  in  NREQ*N  packed operand x, slice i = requester i
req_y  in  NREQ*N  packed operand y
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  requester that owns result
resp_prod  out  N  x*y mod p
resp_err  out  1  1 = timeout abort, resp_prod = 0
mul_en  out  1  to mult_modp en
mul_rst_n  out  1  to mult_modp rst_n (restart strobe)
mul_x  out  N  to mult_modp x
mul_y  out  N  to mult_modp y
mul_prod  in  N  from mult_modp prod
mul_rdy  in  1  from mult_modp data_rdy (level)

Behaviour:
- Reset, sync (rst_n low at a rising edge):
  - state=IDLE; rr pointer=NREQ-1, so requester 0 has first priority.
  - req_ready=0, resp_valid=0, resp_id=0, resp_prod=0, resp_err=0.
  - mul_en=0, mul_x=0, mul_y=0.
  - mul_rst_n follows rst_n low.
- Reset mid-job: aborts immediately. No response is issued and the accepted request is lost; requesters re-issue.
- FSM states: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - req_ready = combinational round-robin grant over req_valid, searching from rr+1 with wrap. At most one bit set; req_ready=0 in all other states.
  - On handshake with requester g: latch req_x[g], req_y[g] into mul_x/mul_y; latch id=g; rr<=g; go to CLEAR.
- CLEAR: exactly 1 cycle. mul_rst_n=0, mul_en=0; mul_x/mul_y stable. Timeout counter cleared. Go to RUN.
- RUN:
  - mul_rst_n=1, mul_en=1; counter increments each cycle.
  - mul_rdy is ignored on the first RUN cycle (multiplier still settling).
  - mul_rdy=1 sampled on a later RUN cycle: resp_prod<=mul_prod, resp_err<=0, go to RESP.
  - Counter reaches TIMEOUT without mul_rdy: resp_prod<=0, resp_err<=1, go to RESP.
  - mul_rdy and timeout in the same cycle: mul_rdy wins.
- RESP:
  - resp_valid=1, mul_en=0, mul_rst_n=1; resp_id/resp_prod/resp_err held stable while resp_ready=0.
  - On resp_valid&resp_ready: go to IDLE. A new grant can appear in the same IDLE cycle that follows, with no dead cycle beyond that.
- Latency: accept at cycle T, mul_rst_n low at T+1, RUN from T+2. mul_rdy sampled at cycle R gives resp_valid at R+1.
- Back-to-back throughput: one job per (multiplier latency + 4) cycles.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 jobs.
- A requester dropping req_valid before being granted is legal (simply skipped). Operands must be stable while valid.
- Widths: mul_prod passed through unmodified; no reduction in this block. Timeout counter width $clog2(TIMEOUT+1), saturating.

Decomposition:
- Shared package curve25519_pkg:
  - N=255 and P = 2^255-19 as an N-bit constant.
  - typedef enum for the arbiter state {IDLE, CLEAR, RUN, RESP}.
  - typedef for the N-bit field element.
- One sub-module rr_arb (NREQ, ID_W): combinational grant from req vector and last pointer; pointer register held in the parent.
- mult_modp is instantiated at the level above, not inside this block.

Test Plan:
- Req0 x=5,y=12, resp_ready=1, real mult_modp -> one-hot req_ready[0] for one cycle; mul_rst_n low exactly one cycle; resp_valid with resp_id=0, resp_prod=60, resp_err=0.
- Req1 x=y=P-1 (0x7fff...ffec) -> resp_prod=1, resp_id=1.
- req_valid=4'b1111 held, stub multiplier with 10-cycle latency -> grant order 0,1,2,3,0. Each resp_id matches; req_ready never multi-hot.
- resp_ready=0 for 20 cycles after resp_valid -> resp_id/resp_prod/resp_err stable, req_ready=0 throughout; accept on cycle 21, then next grant follows.
- Stub mul_rdy tied 0, TIMEOUT=16 -> resp_err=1, resp_prod=0 exactly 16 RUN cycles after RUN entry; controller then accepts the next request normally.
- rst_n low 1 cycle during RUN -> all outputs at reset values the following cycle; no resp_valid for the aborted job; the next request completes with the correct product.
